// File: rtl/mini_vga_scanout.sv
// mini_vga_scanout: VGA timing generator, colour realignment stage and RGB332 decoder with a vblank event flag.
// Optional frame border (forced white on the visible edge pixels) is enabled by defining MINI_VGA_SCANOUT_BORDER_EN.
module mini_vga_scanout #(
    parameter int BPP         = 8,
    parameter int COLOR_DELAY = 7,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic signed [31:0]    ext_count_h,
    output logic signed [31:0]    ext_count_v,
    input  logic signed [BPP-1:0] ext_color,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic                  vblank_pending,
    input  logic                  vblank_ack,
    output logic [31:0]           frame_count
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [31:0] h_cnt;
    logic [31:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        vblank_event;

    assign h_wrap       = (h_cnt == 32'(H_TOTAL - 1));
    assign v_wrap       = (v_cnt == 32'(V_TOTAL - 1));
    assign vblank_event = (h_cnt == 32'd0) && (v_cnt == 32'(V_VISIBLE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 32'd1;
        end else begin
            h_cnt <= h_cnt + 32'd1;
        end
    end

    assign ext_count_h = $signed(h_cnt);
    assign ext_count_v = $signed(v_cnt);

    // Stage-0 timing decode; travels alongside the pixel sources' latency.
    logic de0;
    logic hs0;
    logic vs0;

    always_comb begin
        de0 = (h_cnt < 32'(H_VISIBLE)) && (v_cnt < 32'(V_VISIBLE));
        hs0 = !((h_cnt >= 32'(H_SYNC_START)) && (h_cnt < 32'(H_SYNC_END)));
        vs0 = !((v_cnt >= 32'(V_SYNC_START)) && (v_cnt < 32'(V_SYNC_END)));
    end

    logic [COLOR_DELAY-1:0] de_pipe;
    logic [COLOR_DELAY-1:0] hs_pipe;
    logic [COLOR_DELAY-1:0] vs_pipe;
    logic                   de_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_pipe <= '0;
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            de_pipe[0] <= de0;
            hs_pipe[0] <= hs0;
            vs_pipe[0] <= vs0;
            for (int i = 1; i < COLOR_DELAY; i++) begin
                de_pipe[i] <= de_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    assign de_d = de_pipe[COLOR_DELAY-1];

    logic [7:0] pix;

`ifdef MINI_VGA_SCANOUT_BORDER_EN
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    // Counts are delayed with the syncs so the border lands on the same pixel as the colour.
    logic [HW-1:0] h_pipe [COLOR_DELAY];
    logic [VW-1:0] v_pipe [COLOR_DELAY];
    logic          border_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < COLOR_DELAY; i++) begin
                h_pipe[i] <= '0;
                v_pipe[i] <= '0;
            end
        end else begin
            h_pipe[0] <= h_cnt[HW-1:0];
            v_pipe[0] <= v_cnt[VW-1:0];
            for (int i = 1; i < COLOR_DELAY; i++) begin
                h_pipe[i] <= h_pipe[i-1];
                v_pipe[i] <= v_pipe[i-1];
            end
        end
    end

    assign border_d = (h_pipe[COLOR_DELAY-1] == HW'(0))
                   || (h_pipe[COLOR_DELAY-1] == HW'(H_VISIBLE - 1))
                   || (v_pipe[COLOR_DELAY-1] == VW'(0))
                   || (v_pipe[COLOR_DELAY-1] == VW'(V_VISIBLE - 1));

    always_comb begin
        pix = border_d ? 8'hFF : ext_color[7:0];
    end
`else
    always_comb begin
        pix = ext_color[7:0];
    end
`endif

    // Output register: colour and delayed timing are captured on the same edge, blanked outside de.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_de <= 1'b0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_de <= de_d;
            vga_hs <= hs_pipe[COLOR_DELAY-1];
            vga_vs <= vs_pipe[COLOR_DELAY-1];
            if (de_d) begin
                vga_r <= {pix[7:5], pix[7]};
                vga_g <= {pix[4:2], pix[4]};
                vga_b <= {pix[1:0], pix[1:0]};
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

    // A coincident acknowledge loses to a new event so no vblank is ever missed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_pending <= 1'b0;
            frame_count    <= '0;
        end else if (vblank_event) begin
            vblank_pending <= 1'b1;
            frame_count    <= frame_count + 32'd1;
        end else if (vblank_ack) begin
            vblank_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mini_vga_scanout.sv
// tb_mini_vga_scanout: randomized scoreboard bench for mini_vga_scanout using a reduced raster.
// Expected outputs come from a cycle-index model (div/mod on the cycle count since reset release).
module tb_mini_vga_scanout;

    localparam int HV    = 240;
    localparam int HF    = 8;
    localparam int HSY   = 16;
    localparam int HB    = 16;
    localparam int VV    = 12;
    localparam int VF    = 2;
    localparam int VSY   = 2;
    localparam int VB    = 3;
    localparam int HT    = HV + HF + HSY + HB;
    localparam int VT    = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int CD    = 7;

    typedef struct {
        int         n;
        int         h;
        int         v;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       de;
        logic       hs;
        logic       vs;
        logic       pend;
        int         fc;
        logic       is_e5;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [31:0] ext_count_h;
    logic signed [31:0] ext_count_v;
    logic signed [7:0]  ext_color = '0;
    logic [3:0]         vga_r;
    logic [3:0]         vga_g;
    logic [3:0]         vga_b;
    logic               vga_hs;
    logic               vga_vs;
    logic               vga_de;
    logic               vblank_pending;
    logic               vblank_ack = 1'b0;
    logic [31:0]        frame_count;

    mini_vga_scanout #(
        .BPP(8), .COLOR_DELAY(CD),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset),
        .ext_count_h(ext_count_h), .ext_count_v(ext_count_v),
        .ext_color(ext_color),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vblank_pending(vblank_pending), .vblank_ack(vblank_ack),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    bit         mon_en = 1'b0;
    bit         agg_en = 1'b0;
    int         n = 0;
    logic [7:0] last_color = '0;
    logic       pend_m = 1'b0;
    int         fc_m = 0;
    int         color_mode = 0;
    int         de_cnt = 0;
    int         hs_cnt = 0;
    int         vs_cnt = 0;

    task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Output seen in cycle cyc reflects the count issued CD+1 cycles earlier.
    function automatic exp_t model(input int cyc);
        exp_t e;
        int   m, ph, pv, c;
        e.n = cyc;  e.h = cyc % HT;  e.v = (cyc / HT) % VT;
        e.pend = pend_m;  e.fc = fc_m;
        e.de = 1'b0;  e.hs = 1'b1;  e.vs = 1'b1;
        e.r = '0;  e.g = '0;  e.b = '0;  e.is_e5 = 1'b0;
        if (cyc >= CD + 1) begin
            m  = cyc - CD - 1;
            ph = m % HT;
            pv = (m / HT) % VT;
            c  = int'(last_color);
            e.de = (ph < HV) && (pv < VV);
            e.hs = !((ph >= HV + HF) && (ph < HV + HF + HSY));
            e.vs = !((pv >= VV + VF) && (pv < VV + VF + VSY));
`ifdef MINI_VGA_SCANOUT_BORDER_EN
            if (ph == 0 || ph == HV - 1 || pv == 0 || pv == VV - 1) c = 255;
`endif
            if (e.de) begin
                e.r = 4'((c >> 5) * 2 + (c >> 7));
                e.g = 4'(((c >> 2) & 7) * 2 + ((c >> 4) & 1));
                e.b = 4'((c & 3) * 5);
            end
            e.is_e5 = e.de && (ph == 229) && (pv != 0) && (pv != VV - 1) && (color_mode == 0);
        end
        return e;
    endfunction

    // Called once per cycle at the falling edge: queue the expectation, then drive this cycle's inputs.
    task automatic apply_stimulus();
        int         m, ph, pv;
        logic [7:0] col;
        logic       ack;
        sb.push_back(model(n));
        m  = n - CD;
        ph = (m >= 0) ? m % HT : 0;
        pv = (m >= 0) ? (m / HT) % VT : VT;
        if (color_mode == 0) col = 8'(ph);
        else if (!((ph < HV) && (pv < VV))) col = 8'hFF;
        else col = 8'($urandom);
        ack = (n == 100) || (n == VV * HT + 11) || (n == FRAME + VV * HT)
           || ((color_mode == 1) && ($urandom_range(31) == 0));
        ext_color  = col;
        vblank_ack = ack;
        last_color = col;
        if ((n % HT == 0) && ((n / HT) % VT == VV)) begin
            pend_m = 1'b1;
            fc_m++;
        end else if (ack) begin
            pend_m = 1'b0;
        end
        n++;
    endtask

    // Monitor: pops one expectation per cycle and compares, decoupled from the driver.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check_output("sb_depth", 64'(sb.size()), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_output($sformatf("counts@%0d", e.n), {ext_count_h, ext_count_v},
                                 {32'(e.h), 32'(e.v)});
                    check_output($sformatf("outputs@%0d", e.n),
                                 64'({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, vblank_pending, frame_count}),
                                 64'({e.r, e.g, e.b, e.de, e.hs, e.vs, e.pend, 32'(e.fc)}));
                    if (e.is_e5)
                        check_output("pixel_e5", 64'({vga_r, vga_g, vga_b}), 64'h0F25);
                    if (agg_en && e.n >= CD + 1 && e.n < CD + 1 + 2 * FRAME) begin
                        if (vga_de)  de_cnt++;
                        if (!vga_hs) hs_cnt++;
                        if (!vga_vs) vs_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_counts", {ext_count_h, ext_count_v}, 64'd0);
        check_output("reset_outputs",
                     64'({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, vblank_pending, frame_count}),
                     64'({12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0}));

        @(negedge clk);
        reset = 1'b1;  mon_en = 1'b1;  agg_en = 1'b1;
        n = 0;  pend_m = 1'b0;  fc_m = 0;  color_mode = 0;
        apply_stimulus();
        while (n < 2 * FRAME) begin
            @(negedge clk);
            apply_stimulus();
        end
        agg_en = 1'b0;
        color_mode = 1;
        while (n <= 3 * FRAME + 5 * HT + 100) begin
            @(negedge clk);
            apply_stimulus();
        end

        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_output("midreset_counts", {ext_count_h, ext_count_v}, 64'd0);
        check_output("midreset_outputs",
                     64'({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, vblank_pending, frame_count}),
                     64'({12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0}));
        repeat (3) @(negedge clk);
        sb.delete();
        reset = 1'b1;  mon_en = 1'b1;
        n = 0;  pend_m = 1'b0;  fc_m = 0;
        apply_stimulus();
        while (n < VV * HT + 30) begin
            @(negedge clk);
            apply_stimulus();
        end

        @(negedge clk);
        mon_en = 1'b0;
        #2;
        check_output("de_cycles_2frames", 64'(de_cnt), 64'(2 * HV * VV));
        check_output("hs_low_2frames", 64'(hs_cnt), 64'(2 * VT * HSY));
        check_output("vs_low_2frames", 64'(vs_cnt), 64'(2 * VSY * HT));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mini_vga_scanout.md
# mini_vga_scanout

Video timing generator and scanout stage for the sprite/layer pipeline. Drives `ext_count_h`/`ext_count_v` to the pixel sources, takes back their `ext_color` a fixed number of cycles later, and realigns sync/blank so colour and timing leave together. Decodes RGB332 to 4-bit-per-channel VGA outputs and raises a vblank event with a software acknowledge.

## Interface
Parameters:
- `BPP`, 8: colour width of `ext_color`; RGB332 decode requires 8.
- `COLOR_DELAY`, 7: cycles from a count to its colour on `ext_color`.
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing, in pixels.
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing, in lines.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-low reset.
- `ext_count_h` out 32 signed: horizontal count, 0..H_TOTAL-1.
- `ext_count_v` out 32 signed: vertical count, 0..V_TOTAL-1.
- `ext_color` in BPP signed: pixel colour for the count issued COLOR_DELAY cycles earlier.
- `vga_r`, `vga_g`, `vga_b` out 4: colour outputs.
- `vga_hs`, `vga_vs` out 1: syncs, active-low.
- `vga_de` out 1: display enable.
- `vblank_pending` out 1: vblank event flag.
- `vblank_ack` in 1: one-cycle pulse that clears `vblank_pending`.
- `frame_count` out 32: number of completed visible frames.

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- `ext_count_h` increments every cycle and wraps from H_TOTAL-1 to 0.
- `ext_count_v` increments when h wraps, and wraps from V_TOTAL-1 to 0.
- Counts are registers; their upper bits are zero-extended (always non-negative).
- Decode from the current count, stage 0:
  - de0 = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hs0 = low while H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - vs0 = low while V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
- de0/hs0/vs0 pass through a COLOR_DELAY-deep shift register, then an output register that also samples `ext_color`.
- RGB332 decode, with c = sampled colour:
  - r = {c[7:5], c[7]}
  - g = {c[4:2], c[4]}
  - b = {c[1:0], c[1:0]}
- All three channels are forced to 0 when the delayed de is 0.
- Vblank event: the cycle the counters are h=0, v=V_VISIBLE.
  - On the event, `vblank_pending` is set and `frame_count` increments (wraps at 2^32).
  - `vblank_ack` clears `vblank_pending`.
  - Event and ack in the same cycle: set wins, so the flag stays 1.
  - Ack while the flag is clear: no effect.

## Timing
- Reset (asynchronous, while `reset`=0):
  - counts = 0, `frame_count` = 0, `vblank_pending` = 0.
  - `vga_de` = 0, `vga_hs` = 1, `vga_vs` = 1, rgb = 0.
  - All delay stages are loaded with the inactive values (de=0, hs=vs=1).
- First cycle after reset release: count (0,0) is driven.
- The output register takes its first valid value from `ext_color` COLOR_DELAY cycles after a count is issued.
- Latency: a count driven in cycle t produces rgb/de/hs/vs in cycle t+COLOR_DELAY+1. Colour and syncs are never skewed relative to each other.
- Reset mid-frame: everything returns to reset state immediately; the frame restarts at (0,0) with no partial vblank event.
- `vblank_pending` and `frame_count` update on the clock edge that follows the event cycle.

## Configuration
- Macro: `MINI_VGA_SCANOUT_BORDER_EN`.
- Defined: at delayed-de positions where h==0, h==H_VISIBLE-1, v==0 or v==V_VISIBLE-1, the output colour is forced to 8'hFF (rgb = 15,15,15), overriding `ext_color`. The border uses the delayed counts so it aligns with the syncs.
- Undefined: no override; the colour always comes from `ext_color`. Border logic and the delayed-count pipeline are not synthesised.

## Test plan
- Release reset, run 2 frames:
  - `ext_count_h` sequence 0..799 then 0.
  - `ext_count_v` 0..524.
  - `vga_hs` low exactly 96 cycles per line; `vga_vs` low exactly 2 lines (1600 cycles).
  - `vga_de` high 640 cycles on each of 480 lines.
- Bench drives `ext_color` = low 8 bits of the count h issued 7 cycles earlier: first visible output pixel (h=0) has rgb=0; the pixel for h=0xE5 has r=0xF, g=0x2, b=0x5; de rises exactly COLOR_DELAY+1 cycles after count (0,0).
- Vblank: `vblank_pending` rises one cycle after count (0,480); `frame_count` goes 0 to 1. Ack 10 cycles later clears the flag. Ack asserted in the event cycle of frame 2 leaves the flag 1 and `frame_count` at 2.
- Assert reset at count (300,200) for 3 cycles:
  - outputs go to reset values immediately;
  - `frame_count` = 0;
  - after release the count restarts at (0,0) and the first vblank occurs 480×800 cycles later.
- Drive `ext_color` = 8'hFF during blanking: rgb stays 0 whenever `vga_de` = 0.
- With `MINI_VGA_SCANOUT_BORDER_EN` and `ext_color` = 0:
  - pixels (0,y), (639,y), (x,0), (x,479) output rgb 15,15,15;
  - pixel (1,1) outputs 0.
